// File: rtl/alu_seq_ctrl.sv
// Sequential ALU control: single-cycle ADD/SUB and a fixed-latency shift-add multiplier
// behind a valid/ready request port and a held result port.
module alu_seq_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
  typedef enum logic [1:0] {OpAdd, OpSub, OpMul} op_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;

  op_e               dec_op;
  logic              accept;
  logic [XLEN-1:0]   addsub_res;
  logic [XLEN-1:0]   acc_step;
  logic              mul_last;

  always_comb begin
    dec_op = OpAdd;
    unique case (alu_op)
      2'b00: dec_op = OpAdd;
      2'b01: dec_op = OpSub;
      2'b10: begin
        case ({funct7, funct3})
          10'b0000000_000: dec_op = OpAdd;
          10'b0100000_000: dec_op = OpSub;
          10'b0000001_000: dec_op = OpMul;
          default:         dec_op = OpAdd;
        endcase
      end
      2'b11: dec_op = (funct3 == 3'b001) ? OpSub : OpAdd;
      default: dec_op = OpAdd;
    endcase
  end

  // Flush in IDLE suppresses the accept so a request cannot slip through the abandon.
  assign accept     = in_valid && (state_q == StIdle) && !flush;
  assign addsub_res = (dec_op == OpSub) ? (op_a - op_b) : (op_a + op_b);
  assign acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_last   = (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (dec_op == OpMul) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            result_d = addsub_res;
            zero_d   = (addsub_res == '0);
            state_d  = StDone;
          end
        end
      end
      StMul: begin
        // Fixed XLEN iterations regardless of operand values.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (mul_last) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign out_result = result_q;
  assign out_zero   = zero_q;

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits (SHALL be >= 4).
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > XLEN.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 alu_op  input  2  op class: 00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-008 funct3  input  3  instruction funct3.
REQ-009 funct7  input  7  instruction funct7.
REQ-010 op_a, op_b  input  XLEN each  operands.
REQ-011 flush  input  1  abandon any in-flight operation.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_result  output  XLEN  result.
REQ-015 out_zero  output  1  out_result == 0.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 Decode SHALL be: 00 -> ADD; 01 -> SUB; 10 -> {funct7,funct3} 0000000_000 ADD, 0100000_000 SUB, 0000001_000 MUL, else ADD; 11 -> funct3 000 ADD, 001 SUB, else ADD.
REQ-018 States SHALL be IDLE, MUL, DONE; in_ready = 1 only in IDLE (no bypass from DONE).
REQ-019 Accept occurs on a rising edge where in_valid && in_ready; decode and operands SHALL be sampled only at accept.
REQ-020 ADD/SUB at accept: out_result <= op_a +/- op_b modulo 2^XLEN, state -> DONE; out_valid high in the cycle after accept (latency 1).
REQ-021 MUL at accept: multiplicand, multiplier, accumulator (0) and counter (0) SHALL be loaded, state -> MUL.
REQ-022 In MUL each edge: if multiplier LSB = 1, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter += 1; all truncated to XLEN bits.
REQ-023 On the edge where counter == XLEN-1, the final accumulator SHALL be written to out_result and state -> DONE; out_valid high exactly XLEN+1 cycles after accept.
REQ-024 MUL result SHALL be the low XLEN bits of the unsigned product (identical for signed operands); latency SHALL be fixed, no early termination.
REQ-025 In DONE, out_valid = 1 and out_result/out_zero SHALL hold stable until an edge with out_ready = 1, which returns to IDLE.
REQ-026 in_valid while not IDLE SHALL be ignored; in_valid may stay asserted across ops.
REQ-027 flush = 1 at an edge SHALL force IDLE from any state, discard the op, and deassert out_valid the next cycle; flush in IDLE with in_valid SHALL block the accept.
REQ-028 out_zero SHALL be registered with out_result, 1 iff out_result == 0.

Reset
REQ-029 rst SHALL take priority over flush and all inputs.
REQ-030 After a reset edge: state IDLE, in_ready = 1, out_valid = 0, busy = 0, out_result = 0, out_zero = 1, counter/accumulator = 0.
REQ-031 Reset mid-MUL or in DONE SHALL drop the op with no out_valid pulse.

Verification
REQ-032 alu_op=10, funct7=0000000, funct3=000, A=5, B=7 -> out_valid next cycle, result 12, zero 0.
REQ-033 alu_op=11, funct3=001, A=3, B=5 -> result 0xFFFFFFFE; alu_op=01, A=B=9 -> result 0, zero 1.
REQ-034 funct7=0000001, funct3=000, A=B=0xFFFFFFFF -> busy for 32 cycles, out_valid on cycle 33, result 0x00000001; A=1234, B=5678 -> 7006652.
REQ-035 ADD result with out_ready low 10 cycles -> out_valid/result stable, in_ready 0, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-036 MUL accepted, flush at cycle 10 -> IDLE next cycle, no out_valid; next ADD 1+1 returns 2 at latency 1.
REQ-037 rst asserted mid-MUL and in DONE -> all outputs at REQ-030 values next cycle, no result emitted.
